// File: rtl/qoi_rgb444_decoder.sv
// qoi_rgb444_decoder
// Streaming decoder for a QOI-style format carrying 12-bit RGB444 pixels.
// Opcode bytes come from a packed byte array, literal colours from a packed
// colour stack. One pixel is registered onto rgb per enabled clock until an
// END opcode or the end of the byte array sets the sticky done flag.
module qoi_rgb444_decoder #(
  parameter int STREAM_BYTES = 320,
  parameter int STACK_DEPTH  = 64,
  parameter int INDEX_SIZE   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [STREAM_BYTES*8-1:0]    input_stream,
  input  logic [STACK_DEPTH*12-1:0]    rgbstack,
  output logic [11:0]                  rgb,
  output logic                         done
);

  // One extra count of headroom so the pointer can sit one past the last byte.
  localparam int PTR_W = $clog2(STREAM_BYTES + 1);
  localparam int SP_W  = $clog2(STACK_DEPTH);

  localparam logic [PTR_W-1:0] L_END  = PTR_W'(STREAM_BYTES);
  localparam logic [PTR_W-1:0] L_LAST = PTR_W'(STREAM_BYTES - 1);

  localparam logic [7:0] OP_END = 8'hFF;
  localparam logic [7:0] OP_RGB = 8'hFE;

  // Decode state
  logic [11:0]      r_rgb;             // also serves as the previous pixel
  logic             r_done;
  logic [PTR_W-1:0] r_ptr;
  logic [SP_W-1:0]  r_sp;
  logic [5:0]       r_run;             // repeats still owed by the current RUN
  logic [11:0]      r_table [INDEX_SIZE];

  // Unpacked views of the packed input arrays
  logic [7:0]       w_bytes [STREAM_BYTES];
  logic [11:0]      w_stack [STACK_DEPTH];

  // Next-state values
  logic [7:0]       w_op0;
  logic [7:0]       w_op1;
  logic [PTR_W-1:0] w_ptr_p1;
  logic [PTR_W-1:0] w_ptr_p2;
  logic [3:0]       w_dg;
  logic [11:0]      w_pix;
  logic             w_emit;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [SP_W-1:0]  w_sp_nxt;
  logic [5:0]       w_run_nxt;
  logic             w_done_nxt;
  logic [5:0]       w_slot;

  for (genvar gi = 0; gi < STREAM_BYTES; gi++) begin : g_bytes
    assign w_bytes[gi] = input_stream[gi*8 +: 8];
  end

  for (genvar gs = 0; gs < STACK_DEPTH; gs++) begin : g_stack
    assign w_stack[gs] = rgbstack[gs*12 +: 12];
  end

  assign w_ptr_p1 = r_ptr + PTR_W'(1);
  assign w_ptr_p2 = r_ptr + PTR_W'(2);
  assign w_op0    = w_bytes[r_ptr];
  assign w_op1    = w_bytes[w_ptr_p1];
  assign w_dg     = w_op0[3:0] - 4'd8;

  // Decode the current opcode (or run repeat) into the next pixel and pointers
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_pix      = r_rgb;
    w_emit     = 1'b0;
    w_ptr_nxt  = r_ptr;
    w_sp_nxt   = r_sp;
    w_run_nxt  = r_run;
    w_done_nxt = r_done;

    if (en && !r_done) begin
      if (r_run != 6'd0) begin
        // Pending run: repeat the previous pixel, move past the opcode on the last one
        w_emit    = 1'b1;
        w_run_nxt = r_run - 6'd1;
        if (r_run == 6'd1) w_ptr_nxt = w_ptr_p1;
      end else if (r_ptr >= L_END) begin
        w_done_nxt = 1'b1;
      end else if (w_op0 == OP_END) begin
        w_done_nxt = 1'b1;
      end else if (w_op0 == OP_RGB) begin
        w_emit    = 1'b1;
        w_pix     = w_stack[r_sp];
        w_sp_nxt  = r_sp + SP_W'(1);
        w_ptr_nxt = w_ptr_p1;
      end else begin
        unique case (w_op0[7:6])
          2'b00: begin  // INDEX
            w_emit    = 1'b1;
            w_pix     = r_table[w_op0[5:0]];
            w_ptr_nxt = w_ptr_p1;
          end
          2'b01: begin  // DIFF, each field biased by 2
            w_emit      = 1'b1;
            w_pix[11:8] = r_rgb[11:8] + {2'b00, w_op0[5:4]} - 4'd2;
            w_pix[7:4]  = r_rgb[7:4]  + {2'b00, w_op0[3:2]} - 4'd2;
            w_pix[3:0]  = r_rgb[3:0]  + {2'b00, w_op0[1:0]} - 4'd2;
            w_ptr_nxt   = w_ptr_p1;
          end
          2'b10: begin  // LUMA, needs a second byte
            if (r_ptr == L_LAST) begin
              w_done_nxt = 1'b1;
            end else begin
              w_emit      = 1'b1;
              w_pix[11:8] = r_rgb[11:8] + w_dg + w_op1[7:4] - 4'd8;
              w_pix[7:4]  = r_rgb[7:4]  + w_dg;
              w_pix[3:0]  = r_rgb[3:0]  + w_dg + w_op1[3:0] - 4'd8;
              w_ptr_nxt   = w_ptr_p2;
            end
          end
          default: begin  // RUN: first repeat now, the rest from r_run
            w_emit    = 1'b1;
            w_run_nxt = w_op0[5:0];
            if (w_op0[5:0] == 6'd0) w_ptr_nxt = w_ptr_p1;
          end
        endcase
      end
    end
  end

  // Hash slot of the emitted pixel; 6-bit arithmetic gives the mod 64 directly
  assign w_slot = ({2'b00, w_pix[11:8]} * 6'd3)
                + ({2'b00, w_pix[7:4]}  * 6'd5)
                + ({2'b00, w_pix[3:0]}  * 6'd7);

  // Register pixel, pointers, run counter and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_rgb  <= 12'h000;
      r_done <= 1'b0;
      r_ptr  <= '0;
      r_sp   <= '0;
      r_run  <= 6'd0;
    end else begin
      if (w_emit) r_rgb <= w_pix;
      r_done <= w_done_nxt;
      r_ptr  <= w_ptr_nxt;
      r_sp   <= w_sp_nxt;
      r_run  <= w_run_nxt;
    end
  end

  // Seen-pixel table: record every emitted pixel at its hash slot
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this table is reset because INDEX ops may read a slot before it
    // was ever written, and the decoded output must be defined then.
    if (!rst_n) begin
      for (int i = 0; i < INDEX_SIZE; i++) r_table[i] <= 12'h000;
    end else if (w_emit) begin
      r_table[w_slot] <= w_pix;
    end
  end

  assign rgb  = r_rgb;
  assign done = r_done;

endmodule

// File: tb/tb_qoi_rgb444_decoder.sv
// tb_qoi_rgb444_decoder
// Directed bench for qoi_rgb444_decoder: short hand-built streams with
// hand-computed pixel sequences, enable hold, mid-run reset, table clear
// on reset, and the end-of-array LUMA truncation.
module tb_qoi_rgb444_decoder;

  localparam int STREAM_BYTES = 320;
  localparam int STACK_DEPTH  = 64;

  logic                      clk;
  logic                      rst_n;
  logic                      en;
  logic [STREAM_BYTES*8-1:0] input_stream;
  logic [STACK_DEPTH*12-1:0] rgbstack;
  logic [11:0]               rgb;
  logic                      done;

  int n_checks = 0;
  int n_fail   = 0;

  qoi_rgb444_decoder #(
    .STREAM_BYTES(STREAM_BYTES),
    .STACK_DEPTH (STACK_DEPTH),
    .INDEX_SIZE  (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .input_stream(input_stream),
    .rgbstack    (rgbstack),
    .rgb         (rgb),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [11:0] exp_rgb, input logic exp_done);
    check({tag, ".rgb"}, rgb, exp_rgb);
    check({tag, ".done"}, {11'd0, done}, {11'd0, exp_done});
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input int idx, input logic [7:0] b);
    input_stream[idx*8 +: 8] = b;
  endtask

  task automatic put_lit(input int idx, input logic [11:0] c);
    rgbstack[idx*12 +: 12] = c;
  endtask

  task automatic clear_inputs();
    input_stream = '0;
    rgbstack     = '0;
  endtask

  // Pulse reset between clock edges
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clear_inputs();
    #1;
    check_px("reset", 12'h000, 1'b0);
    #10;
    rst_n = 1'b1;

    // Literals then END
    tick();
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'hFE); put_byte(2, 8'hFF);
    put_lit(0, 12'hFFF); put_lit(1, 12'hFF0);
    do_reset();
    en = 1'b1;
    tick(); check_px("lit0", 12'hFFF, 1'b0);
    tick(); check_px("lit1", 12'hFF0, 1'b0);
    tick(); check_px("lit_end", 12'hFF0, 1'b1);
    tick(); check_px("lit_frozen", 12'hFF0, 1'b1);

    // RUN of 3 after a literal
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'hC2); put_byte(2, 8'hFF);
    put_lit(0, 12'hF0F);
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); check_px($sformatf("run%0d", i), 12'hF0F, 1'b0);
    end
    tick(); check_px("run_end", 12'hF0F, 1'b1);

    // DIFF with channel wrap
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'h6B); put_byte(2, 8'h55); put_byte(3, 8'hFF);
    put_lit(0, 12'hF0F);
    do_reset();
    en = 1'b1;
    tick(); check_px("diff_lit", 12'hF0F, 1'b0);
    tick(); check_px("diff_bwrap", 12'hF00, 1'b0);
    tick(); check_px("diff_minus1", 12'hEFF, 1'b0);
    tick(); check_px("diff_end", 12'hEFF, 1'b1);

    // LUMA with wrap; END straight after proves a two-byte advance
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'h8F); put_byte(2, 8'h72); put_byte(3, 8'hFF);
    put_lit(0, 12'hF0F);
    do_reset();
    en = 1'b1;
    tick(); check_px("luma_lit", 12'hF0F, 1'b0);
    tick(); check_px("luma", 12'h570, 1'b0);
    tick(); check_px("luma_end", 12'h570, 1'b1);

    // INDEX and enable hold
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'hFE); put_byte(2, 8'h16); put_byte(3, 8'hFF);
    put_lit(0, 12'hF0F); put_lit(1, 12'hFFF);
    do_reset();
    en = 1'b1;
    tick(); check_px("idx_lit0", 12'hF0F, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); check_px($sformatf("hold%0d", i), 12'hF0F, 1'b0);
    end
    en = 1'b1;
    tick(); check_px("idx_lit1", 12'hFFF, 1'b0);
    tick(); check_px("idx_slot22", 12'hF0F, 1'b0);
    tick(); check_px("idx_end", 12'hF0F, 1'b1);

    // Reset clears the table: slot 22 held F0F before this reset
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'h16); put_byte(2, 8'hFF);
    put_lit(0, 12'hABC);
    do_reset();
    en = 1'b1;
    tick(); check_px("tclr_lit", 12'hABC, 1'b0);
    tick(); check_px("tclr_slot22", 12'h000, 1'b0);
    tick(); check_px("tclr_end", 12'h000, 1'b1);

    // Reset mid-run restarts at byte 0 and stack entry 0
    en = 1'b0;
    clear_inputs();
    put_byte(0, 8'hFE); put_byte(1, 8'hC5); put_byte(2, 8'hFF);
    put_lit(0, 12'hF0F); put_lit(1, 12'h123);
    do_reset();
    en = 1'b1;
    tick(); tick(); tick();
    check_px("pre_reset", 12'hF0F, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_px("mid_reset", 12'h000, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); check_px($sformatf("restart%0d", i), 12'hF0F, 1'b0);
    end
    tick(); check_px("restart_end", 12'hF0F, 1'b1);

    // End of array: 319 DIFF(B+1) bytes, then a LUMA first byte at the last index
    en = 1'b0;
    clear_inputs();
    for (int i = 0; i < STREAM_BYTES - 1; i++) put_byte(i, 8'h6B);
    put_byte(STREAM_BYTES - 1, 8'h80);
    do_reset();
    en = 1'b1;
    for (int i = 0; i < STREAM_BYTES - 1; i++) tick();
    check_px("eoa_last_px", 12'h00F, 1'b0);
    tick(); check_px("eoa_luma_trunc", 12'h00F, 1'b1);
    tick(); check_px("eoa_frozen", 12'h00F, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
